// File: rtl/biu_defs_pkg.sv
// -----------------------------------------------------------------------------
// biu_defs_pkg
// Shared definitions for the bus-interface-unit prefetch path: word and
// physical-address widths, instruction-word width, immediate flag position,
// fetch FSM state encodings and the segment:offset address helper.
// -----------------------------------------------------------------------------
package biu_defs_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int PADDR_SIZE   = 20;
    localparam int INSTR_WIDTH  = 32;
    localparam int IMM_FLAG_BIT = 15;

    typedef logic [WORD_SIZE-1:0]   word_t;
    typedef logic [PADDR_SIZE-1:0]  paddr_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Real-mode physical address; the carry out of bit 19 is discarded so the
    // address wraps inside the 1 MiB space.
    function automatic paddr_t phys_addr(input word_t seg, input word_t off);
        return {seg, 4'h0} + {4'h0, off};
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
// DEPTH-entry circular word FIFO for the instruction prefetch queue.
// One word may be pushed and zero, one or two words popped per cycle; the two
// oldest words are exposed so the consumer can assemble a two-word
// instruction. clear empties the queue synchronously and beats push/pop.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   clear      in   synchronous flush of the queue contents
//   push       in   write push_data at the tail
//   push_data  in   word to write
//   pop_cnt    in   number of words to retire from the head (0..2)
//   head0      out  oldest word (valid when count >= 1)
//   head1      out  second-oldest word (valid when count >= 2)
//   count      out  number of words held
// -----------------------------------------------------------------------------
module prefetch_fifo
    import biu_defs_pkg::*;
#(
    parameter int DEPTH = 3,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  word_t            push_data,
    input  logic [1:0]       pop_cnt,
    output word_t            head0,
    output word_t            head1,
    output logic [CNT_W-1:0] count
);

    word_t            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_add(wr_ptr, 1);
            rd_ptr <= ptr_add(rd_ptr, int'(pop_cnt));
            count  <= count + CNT_W'(push) - CNT_W'(pop_cnt);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are meaningful, and the top masks the
    // outputs while nothing valid is held.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[ptr_add(rd_ptr, 1)];

endmodule

// File: rtl/biu_prefetch_queue.sv
// -----------------------------------------------------------------------------
// biu_prefetch_queue
// Instruction prefetcher: reads 16-bit words from {cs_seg,4'h0}+fetch_ip,
// buffers them in a QUEUE_WORDS-deep queue and presents complete
// instructions to the execution unit in instruction_and_imm format:
//   head[15]=1 -> {w0,w1}       (two words, instr_ip += 4)
//   head[15]=0 -> {16'h0,w0}    (one word,  instr_ip += 2)
// An EU redirect (flush) empties the queue and restarts fetch at flush_ip;
// a read already on the bus when a flush arrives is completed and discarded.
//
// Optional build macro: FETCH_PERF_CNT_EN adds the fetch_cnt (accepted,
// non-dropped words) and stall_cnt (cycles EU ready but nothing valid)
// saturating counters.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   cs_seg             code segment, sampled at each fetch issue
//   flush, flush_ip    redirect request and target IP
//   mem_rd_req/addr    read request (held until ack) and physical address
//   mem_rd_ack/data    one-cycle acknowledge with read data
//   instr_valid/ready  instruction handshake with the EU
//   instr_out          assembled instruction word
//   instr_ip           IP of the instruction in instr_out
//   queue_count        words currently queued
//   fetch_cnt          (FETCH_PERF_CNT_EN) accepted word counter
//   stall_cnt          (FETCH_PERF_CNT_EN) starved-ready cycle counter
// -----------------------------------------------------------------------------
module biu_prefetch_queue
    import biu_defs_pkg::*;
#(
    parameter int          QUEUE_WORDS = 3,
    parameter logic [15:0] RESET_IP    = 16'h0000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [15:0]                        cs_seg,
    input  logic                               flush,
    input  logic [15:0]                        flush_ip,
    output logic                               mem_rd_req,
    output logic [19:0]                        mem_addr,
    input  logic                               mem_rd_ack,
    input  logic [15:0]                        mem_rd_data,
    output logic                               instr_valid,
    input  logic                               instr_ready,
    output logic [31:0]                        instr_out,
    output logic [15:0]                        instr_ip,
    output logic [$clog2(QUEUE_WORDS+1)-1:0]   queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                        fetch_cnt,
    output logic [31:0]                        stall_cnt
`endif
);

    localparam int CNT_W = $clog2(QUEUE_WORDS + 1);

    if (QUEUE_WORDS < 2) begin : g_bad_depth
        $error("biu_prefetch_queue: QUEUE_WORDS must be at least 2");
    end

    fetch_state_e     state;
    word_t            fetch_ip;
    word_t            head0;
    word_t            head1;
    logic [CNT_W-1:0] count;
    logic             head_imm;
    logic             pop;
    logic [1:0]       pop_cnt;
    logic             push;
    logic             can_issue;
    word_t            issue_ip;

    prefetch_fifo #(
        .DEPTH (QUEUE_WORDS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (mem_rd_data),
        .pop_cnt   (pop_cnt),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    // Instruction assembly works purely from queued words, so read data
    // reaches instr_out one clock after its acknowledge at the earliest.
    assign head_imm    = head0[IMM_FLAG_BIT];
    assign instr_valid = ((count != '0) && !head_imm) || (count >= CNT_W'(2));
    assign instr_out   = !instr_valid ? '0
                       : head_imm     ? {head0, head1}
                       :                {16'h0000, head0};
    assign queue_count = count;

    // A flush in the same cycle wins over both the pop and the read data.
    assign pop     = instr_valid && instr_ready && !flush;
    assign pop_cnt = !pop ? 2'd0 : (head_imm ? 2'd2 : 2'd1);
    assign push    = mem_rd_ack && (state == ST_REQ) && !flush;

    // In IDLE nothing is in flight, so one free slot is enough to issue.
    // A flush empties the queue, so it can always restart fetch at once.
    assign can_issue = flush || (count < CNT_W'(QUEUE_WORDS));
    assign issue_ip  = flush ? flush_ip : fetch_ip;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            mem_rd_req <= 1'b0;
            mem_addr   <= '0;
            fetch_ip   <= RESET_IP;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Acks seen here are strays (e.g. after a reset mid-read).
                    fetch_ip <= issue_ip;
                    if (can_issue) begin
                        state      <= ST_REQ;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= phys_addr(cs_seg, issue_ip);
                    end
                end
                ST_REQ: begin
                    if (mem_rd_ack) begin
                        state      <= ST_IDLE;
                        mem_rd_req <= 1'b0;
                        fetch_ip   <= flush ? flush_ip : fetch_ip + 16'd2;
                    end else if (flush) begin
                        state    <= ST_DRAIN;
                        fetch_ip <= flush_ip;
                    end
                end
                ST_DRAIN: begin
                    if (flush) fetch_ip <= flush_ip;
                    if (mem_rd_ack) begin
                        state      <= ST_IDLE;
                        mem_rd_req <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_rd_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_ip <= RESET_IP;
        end else if (flush) begin
            instr_ip <= flush_ip;
        end else if (pop) begin
            instr_ip <= instr_ip + {13'b0, pop_cnt, 1'b0};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && (fetch_cnt != '1))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (instr_ready && !instr_valid && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_biu_prefetch_queue
// Self-checking bench for biu_prefetch_queue: a memory responder with
// programmable acknowledge latency, a table of expected instructions for the
// main stream, and hand-written sequences for redirects, address wrap, reset
// during a read and (when FETCH_PERF_CNT_EN is defined) the counters.
// -----------------------------------------------------------------------------
module tb_biu_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs_seg;
    logic        flush;
    logic [15:0] flush_ip;
    logic        mem_rd_req;
    logic [19:0] mem_addr;
    logic        mem_rd_ack;
    logic [15:0] mem_rd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [15:0] instr_ip;
    logic [1:0]  queue_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    biu_prefetch_queue #(
        .QUEUE_WORDS (3),
        .RESET_IP    (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cs_seg      (cs_seg),
        .flush       (flush),
        .flush_ip    (flush_ip),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_ip    (instr_ip),
        .queue_count (queue_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- memory model / responder ----------------
    logic [15:0] mem [logic [19:0]];
    logic [19:0] addr_log [$];
    int          ack_delay  = 0;
    int          ack_budget = 1000000;

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    initial begin
        mem_rd_ack  = 1'b0;
        mem_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            mem_rd_ack = 1'b0;
            if (mem_rd_req && ack_budget > 0) begin
                ack_budget--;
                repeat (ack_delay) @(negedge clk);
                addr_log.push_back(mem_addr);
                mem_rd_data = mem_rd(mem_addr);
                mem_rd_ack  = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) timeout_fail(name);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_rd_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_rd_req) timeout_fail(name);
    endtask

    task automatic pop_one();
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    typedef struct {
        int          stall;      // cycles to hold instr_ready low first
        logic [31:0] exp_instr;
        logic [15:0] exp_ip;
    } vec_t;

    vec_t vecs [6];
    int   base;

    initial begin
        // program image at CS=0x0002 (physical base 0x00020)
        mem[20'h00020] = 16'h8020; mem[20'h00022] = 16'h0001;
        mem[20'h00024] = 16'h4148; mem[20'h00026] = 16'h1234;
        mem[20'h00028] = 16'h8ABC; mem[20'h0002A] = 16'h5678;
        mem[20'h0002C] = 16'h0007; mem[20'h0002E] = 16'h9000;
        mem[20'h00030] = 16'hFFFF;
        mem[20'h00060] = 16'h0BAD;   // read that a redirect must discard
        mem[20'h00120] = 16'h0042;
        mem[20'h0FFEE] = 16'h8111; mem[20'hFFFF0] = 16'h2222;
        mem[20'hFFFF2] = 16'h0033;
        mem[20'h000A0] = 16'h8001;

        vecs[0] = '{0,  32'h80200001, 16'h0000};
        vecs[1] = '{0,  32'h00004148, 16'h0004};
        vecs[2] = '{20, 32'h00001234, 16'h0006};
        vecs[3] = '{0,  32'h8ABC5678, 16'h0008};
        vecs[4] = '{3,  32'h00000007, 16'h000C};
        vecs[5] = '{0,  32'h9000FFFF, 16'h000E};

        reset       = 1'b1;
        cs_seg      = 16'h0002;
        flush       = 1'b0;
        flush_ip    = 16'h0000;
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req",   32'(mem_rd_req),  32'h0);
        check("rst_addr",  32'(mem_addr),    32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr_out,        32'h0);
        check("rst_count", 32'(queue_count), 32'h0);
        check("rst_ip",    32'(instr_ip),    32'h0);
        reset = 1'b0;

        // ---------------- main stream ----------------
        for (int i = 0; i < 6; i++) begin
            repeat (vecs[i].stall) @(negedge clk);
            if (vecs[i].stall >= 20) begin
                check("full_count", 32'(queue_count), 32'd3);
                check("full_noreq", 32'(mem_rd_req),  32'd0);
            end
            wait_valid($sformatf("vec%0d_valid", i));
            check($sformatf("vec%0d_instr", i), instr_out,        vecs[i].exp_instr);
            check($sformatf("vec%0d_ip", i),    32'(instr_ip),    32'(vecs[i].exp_ip));
            pop_one();
        end
        for (int k = 0; k < 9; k++)
            check($sformatf("addr%0d", k), 32'(addr_log[k]), 32'(20'h00020 + 20'(2 * k)));

        // ---------------- redirect during a pending read ----------------
        repeat (12) @(negedge clk);          // queue full, request idle
        ack_delay = 3;
        flush = 1'b1; flush_ip = 16'h0040;
        @(negedge clk);
        flush = 1'b0;
        check("fl_idle_valid", 32'(instr_valid), 32'd0);
        check("fl_idle_count", 32'(queue_count), 32'd0);
        check("fl_idle_ip",    32'(instr_ip),    32'h0040);
        check("fl_idle_req",   32'(mem_rd_req),  32'd1);
        check("fl_idle_addr",  32'(mem_addr),    32'h00060);
        flush = 1'b1; flush_ip = 16'h0100;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);           // dropped ack lands in here
        check("drain_valid", 32'(instr_valid), 32'd0);
        check("drain_count", 32'(queue_count), 32'd0);
        check("drain_req",   32'(mem_rd_req),  32'd0);
        check("drain_ip",    32'(instr_ip),    32'h0100);
        @(negedge clk);
        check("redir_req",  32'(mem_rd_req), 32'd1);
        check("redir_addr", 32'(mem_addr),   32'h00120);
        wait_valid("redir_valid");
        check("redir_instr", instr_out,     32'h00000042);
        check("redir_ip",    32'(instr_ip), 32'h0100);
        ack_delay = 0;

        // ---------------- 20-bit address and IP wrap ----------------
        repeat (12) @(negedge clk);
        base   = addr_log.size();
        cs_seg = 16'hFFFF;
        flush  = 1'b1; flush_ip = 16'hFFFE;
        @(negedge clk);
        flush = 1'b0;
        check("wrap_req",  32'(mem_rd_req), 32'd1);
        check("wrap_addr", 32'(mem_addr),   32'h0FFEE);
        wait_valid("wrap_valid");
        check("wrap_addr1", 32'(addr_log[base + 1]), 32'hFFFF0);
        check("wrap_instr", instr_out,     32'h81112222);
        check("wrap_ip",    32'(instr_ip), 32'hFFFE);
        pop_one();
        wait_valid("wrap2_valid");
        check("wrap2_instr", instr_out,     32'h00000033);
        check("wrap2_ip",    32'(instr_ip), 32'h0002);

        // ---------------- reset during a read ----------------
        repeat (12) @(negedge clk);
        ack_delay = 3;
        pop_one();
        wait_req("rstreq_req");
        reset = 1'b1;
        @(negedge clk);
        check("rstreq_req",   32'(mem_rd_req),  32'd0);
        check("rstreq_count", 32'(queue_count), 32'd0);
        check("rstreq_ip",    32'(instr_ip),    32'h0000);
        cs_seg = 16'h0002;
        repeat (3) @(negedge clk);           // stray ack arrives under reset
        ack_delay = 0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(queue_count), 32'd0);
        check("post_rst_addr",  32'(mem_addr),    32'h00020);

`ifdef FETCH_PERF_CNT_EN
        // ---------------- performance counters ----------------
        // 3 fill words, 1 word dropped by a redirect, 1 lone immediate head
        // word, then 7 cycles of ready with nothing valid.
        repeat (15) @(negedge clk);
        check("perf_fill", 32'(queue_count), 32'd3);
        ack_budget = 2;
        ack_delay  = 3;
        flush = 1'b1; flush_ip = 16'h0040;
        @(negedge clk);
        flush = 1'b1; flush_ip = 16'h0080;
        @(negedge clk);
        flush = 1'b0;
        begin
            int n = 0;
            while (queue_count != 2'd1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (queue_count != 2'd1) timeout_fail("perf_lone_word");
        end
        check("perf_novalid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        repeat (7) @(negedge clk);
        instr_ready = 1'b0;
        @(negedge clk);
        check("perf_fetch_cnt", fetch_cnt, 32'd4);
        check("perf_stall_cnt", stall_cnt, 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
